score_keeper: RTL and testbench

Two-player billiard score keeper that accumulates per-player points in two-digit BCD (00–99). It tracks whose turn it is, detects the winning score, and drives a blink enable for the winner's digits. It sits directly upstream of the seven-segment decoders: each of the four 4-bit digit outputs feeds one `hex_ss` instance's `iDIG` input. Event pulses arrive from the game controller (pocket detection, foul logic, end-of-shot detection).

---
 rtl/score_keeper.sv | 154 +++++++++++++++
 tb/tb_score_keeper.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/score_keeper.sv
// Two-player billiard score keeper: per-player two-digit BCD scores, turn
// tracking, win detection and a blink enable for the winner's digits.
module score_keeper #(
  parameter logic [7:0]  WIN_SCORE = 8'h15,
  parameter int unsigned BLINK_DIV = 25_000_000
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfGame,
  input  logic       ballPocketed,
  input  logic [3:0] points,
  input  logic       foul,
  input  logic       turnEnd,
  output logic [3:0] p0Tens,
  output logic [3:0] p0Ones,
  output logic [3:0] p1Tens,
  output logic [3:0] p1Ones,
  output logic       currentPlayer,
  output logic       gameOver,
  output logic       winner,
  output logic       blinkOn
);

  localparam int unsigned CW = $clog2(BLINK_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(BLINK_DIV - 1);

  typedef enum logic {PLAY, OVER} state_t;

  state_t        state, state_n;
  logic [3:0]    p0t_n, p0o_n, p1t_n, p1o_n;
  logic          cur_n, win_n, scored, scored_n, blink_n;
  logic [CW-1:0] cnt, cnt_n;

  logic [3:0] pts_c, sel_t, sel_o, add_t, add_o;
  logic [4:0] sum;
  logic       toggle;

  // BCD add of the clamped points onto the current player's score,
  // saturating at 99 instead of wrapping.
  always_comb begin
    pts_c = (points > 4'd9) ? 4'd9 : points;
    sel_t = currentPlayer ? p1Tens : p0Tens;
    sel_o = currentPlayer ? p1Ones : p0Ones;
    sum   = {1'b0, sel_o} + {1'b0, pts_c};
    add_t = sel_t;
    add_o = sum[3:0];
    if (sum > 5'd9) begin
      add_o = 4'(sum - 5'd10);
      if (sel_t == 4'd9) begin
        add_t = 4'd9;
        add_o = 4'd9;
      end else begin
        add_t = sel_t + 4'd1;
      end
    end
  end

  // Next-state logic: event priority is startOfGame, foul, ballPocketed, turnEnd.
  always_comb begin
    state_n  = state;
    p0t_n    = p0Tens;
    p0o_n    = p0Ones;
    p1t_n    = p1Tens;
    p1o_n    = p1Ones;
    cur_n    = currentPlayer;
    win_n    = winner;
    scored_n = scored;
    blink_n  = blinkOn;
    cnt_n    = cnt;
    toggle   = 1'b0;

    case (state)
      PLAY: begin
        cnt_n   = '0;
        blink_n = 1'b1;
        if (foul) begin
          toggle   = 1'b1;
          scored_n = 1'b0;
        end else if (ballPocketed) begin
          if (currentPlayer) begin
            p1t_n = add_t;
            p1o_n = add_o;
          end else begin
            p0t_n = add_t;
            p0o_n = add_o;
          end
          scored_n = 1'b1;
          if ({add_t, add_o} >= WIN_SCORE) begin
            state_n = OVER;
            win_n   = currentPlayer;
          end
        end
        // A foul already passed the turn; turnEnd must not toggle it back.
        if (turnEnd) begin
          if (!foul && !scored_n) toggle = 1'b1;
          scored_n = 1'b0;
        end
        if (toggle) cur_n = ~currentPlayer;
      end
      OVER: begin
        if (cnt == CNT_MAX) begin
          cnt_n   = '0;
          blink_n = ~blinkOn;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: state_n = PLAY;
    endcase

    if (startOfGame) begin
      state_n  = PLAY;
      p0t_n    = '0;
      p0o_n    = '0;
      p1t_n    = '0;
      p1o_n    = '0;
      cur_n    = 1'b0;
      win_n    = 1'b0;
      scored_n = 1'b0;
      blink_n  = 1'b1;
      cnt_n    = '0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state         <= PLAY;
      p0Tens        <= '0;
      p0Ones        <= '0;
      p1Tens        <= '0;
      p1Ones        <= '0;
      currentPlayer <= 1'b0;
      winner        <= 1'b0;
      scored        <= 1'b0;
      blinkOn       <= 1'b1;
      cnt           <= '0;
    end else begin
      state         <= state_n;
      p0Tens        <= p0t_n;
      p0Ones        <= p0o_n;
      p1Tens        <= p1t_n;
      p1Ones        <= p1o_n;
      currentPlayer <= cur_n;
      winner        <= win_n;
      scored        <= scored_n;
      blinkOn       <= blink_n;
      cnt           <= cnt_n;
    end
  end

  assign gameOver = (state == OVER);

endmodule

// File: tb/tb_score_keeper.sv
// Bench for score_keeper: two instances (win at 15 and at 99, blink period 4)
// share stimulus and are checked every cycle against an integer-score model.
module tb_score_keeper;

  logic clk = 1'b0;
  logic resetN, sog, bp, fl, te;
  logic [3:0] pts;

  logic [1:0][3:0] p0t, p0o, p1t, p1o;
  logic [1:0] cp, go, wn, bl;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: plain decimal scores and a cycle count since game over.
  int  m_score [2][2];
  bit  m_cur [2], m_scored [2], m_over [2], m_win [2];
  int  m_ovcyc [2];
  int  m_target [2] = '{15, 99};

  always #5 clk = ~clk;

  score_keeper #(.WIN_SCORE(8'h15), .BLINK_DIV(4)) dut0 (
    .clk(clk), .resetN(resetN), .startOfGame(sog), .ballPocketed(bp),
    .points(pts), .foul(fl), .turnEnd(te),
    .p0Tens(p0t[0]), .p0Ones(p0o[0]), .p1Tens(p1t[0]), .p1Ones(p1o[0]),
    .currentPlayer(cp[0]), .gameOver(go[0]), .winner(wn[0]), .blinkOn(bl[0]));

  score_keeper #(.WIN_SCORE(8'h99), .BLINK_DIV(4)) dut1 (
    .clk(clk), .resetN(resetN), .startOfGame(sog), .ballPocketed(bp),
    .points(pts), .foul(fl), .turnEnd(te),
    .p0Tens(p0t[1]), .p0Ones(p0o[1]), .p1Tens(p1t[1]), .p1Ones(p1o[1]),
    .currentPlayer(cp[1]), .gameOver(go[1]), .winner(wn[1]), .blinkOn(bl[1]));

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_score[i][0] = 0;
      m_score[i][1] = 0;
      m_cur[i] = 0; m_scored[i] = 0; m_over[i] = 0; m_win[i] = 0; m_ovcyc[i] = 0;
    end
  endtask

  task automatic model_step(input bit s, input bit b, input int p, input bit f, input bit t);
    int add;
    bit tg;
    for (int i = 0; i < 2; i++) begin
      if (s) begin
        m_score[i][0] = 0;
        m_score[i][1] = 0;
        m_cur[i] = 0; m_scored[i] = 0; m_over[i] = 0; m_win[i] = 0; m_ovcyc[i] = 0;
      end else if (m_over[i]) begin
        m_ovcyc[i]++;
      end else begin
        tg = 0;
        if (f) begin
          tg = 1;
          m_scored[i] = 0;
        end else if (b) begin
          add = (p > 9) ? 9 : p;
          m_score[i][m_cur[i]] = m_score[i][m_cur[i]] + add;
          if (m_score[i][m_cur[i]] > 99) m_score[i][m_cur[i]] = 99;
          m_scored[i] = 1;
          if (m_score[i][m_cur[i]] >= m_target[i]) begin
            m_over[i] = 1;
            m_win[i] = m_cur[i];
            m_ovcyc[i] = 0;
          end
        end
        if (t) begin
          if (!f && !m_scored[i]) tg = 1;
          m_scored[i] = 0;
        end
        if (tg) m_cur[i] = ~m_cur[i];
      end
    end
  endtask

  task automatic check_all();
    int eb;
    for (int i = 0; i < 2; i++) begin
      eb = m_over[i] ? (((m_ovcyc[i] / 4) % 2) == 0) : 1;
      check($sformatf("d%0d_p0Tens", i), int'(p0t[i]), m_score[i][0] / 10);
      check($sformatf("d%0d_p0Ones", i), int'(p0o[i]), m_score[i][0] % 10);
      check($sformatf("d%0d_p1Tens", i), int'(p1t[i]), m_score[i][1] / 10);
      check($sformatf("d%0d_p1Ones", i), int'(p1o[i]), m_score[i][1] % 10);
      check($sformatf("d%0d_currentPlayer", i), int'(cp[i]), int'(m_cur[i]));
      check($sformatf("d%0d_gameOver", i), int'(go[i]), int'(m_over[i]));
      check($sformatf("d%0d_winner", i), int'(wn[i]), int'(m_win[i]));
      check($sformatf("d%0d_blinkOn", i), int'(bl[i]), eb);
    end
  endtask

  task automatic tick(input bit s, input bit b, input int p, input bit f, input bit t);
    sog = s; bp = b; pts = 4'(p); fl = f; te = t;
    @(posedge clk);
    model_step(s, b, p, f, t);
    #1;
    check_all();
    sog = 0; bp = 0; pts = 4'd0; fl = 0; te = 0;
  endtask

  int blink_exp [9] = '{1, 1, 1, 1, 0, 0, 0, 0, 1};

  initial begin
    resetN = 1; sog = 0; bp = 0; pts = 4'd0; fl = 0; te = 0;
    model_reset();
    #2 resetN = 0;
    #1 check_all();
    @(negedge clk) resetN = 1;

    tick(1, 0, 0, 0, 0);
    // BCD carry: 7 + 5 = 12 for player 0
    tick(0, 1, 7, 0, 0);
    tick(0, 1, 5, 0, 0);
    check("carry_p0Tens", int'(p0t[0]), 1);
    check("carry_p0Ones", int'(p0o[0]), 2);
    // turnEnd after scoring keeps the turn; a second one passes it
    tick(0, 0, 0, 0, 1);
    check("turn_after_score", int'(cp[0]), 0);
    tick(0, 0, 0, 0, 1);
    check("turn_no_pocket", int'(cp[0]), 1);
    // pocket plus turnEnd together: player 1 keeps the turn
    tick(0, 1, 3, 0, 1);
    check("pocket_turnEnd_player", int'(cp[0]), 1);
    check("pocket_turnEnd_p1Ones", int'(p1o[0]), 3);
    // foul discards a same-cycle pocket and toggles once, even with turnEnd
    tick(0, 1, 5, 1, 1);
    check("foul_p1Ones", int'(p1o[0]), 3);
    check("foul_player", int'(cp[0]), 0);
    tick(0, 0, 0, 0, 1);
    tick(0, 1, 9, 0, 0);
    check("p1_at_12_tens", int'(p1t[0]), 1);
    check("p1_at_12_ones", int'(p1o[0]), 2);
    // winning pocket: 12 + 4 = 16 >= 15
    tick(0, 1, 4, 0, 0);
    check("win_gameOver", int'(go[0]), 1);
    check("win_winner", int'(wn[0]), 1);
    check("win_p1Ones", int'(p1o[0]), 6);
    check("blink_seq0", int'(bl[0]), blink_exp[0]);
    // frozen after the win
    tick(0, 1, 9, 0, 0);
    check("blink_seq1", int'(bl[0]), blink_exp[1]);
    tick(0, 0, 0, 1, 0);
    check("blink_seq2", int'(bl[0]), blink_exp[2]);
    tick(0, 0, 0, 0, 1);
    check("blink_seq3", int'(bl[0]), blink_exp[3]);
    check("frozen_p1Ones", int'(p1o[0]), 6);
    check("frozen_p0Ones", int'(p0o[0]), 2);
    check("frozen_player", int'(cp[0]), 1);
    for (int k = 4; k < 9; k++) begin
      tick(0, 0, 0, 0, 0);
      check($sformatf("blink_seq%0d", k), int'(bl[0]), blink_exp[k]);
    end
    tick(0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0);
    // asynchronous reset in the middle of a blink count
    #2 resetN = 0;
    model_reset();
    #1;
    check("async_gameOver", int'(go[0]), 0);
    check("async_blinkOn", int'(bl[0]), 1);
    check_all();
    @(negedge clk) resetN = 1;
    tick(0, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0);
    check("sog_blinkOn", int'(bl[0]), 1);
    check("sog_gameOver", int'(go[0]), 0);
    // clamped points: 4'hC adds 9
    tick(0, 1, 12, 0, 0);
    check("clamp_p0Ones", int'(p0o[0]), 9);
    check("clamp_p0Tens", int'(p0t[0]), 0);
    // saturation on the 99 instance: push player 0 to 98, then add 9
    for (int k = 0; k < 9; k++) tick(0, 1, 9, 0, 0);
    tick(0, 1, 8, 0, 0);
    check("near_top_tens", int'(p0t[1]), 9);
    check("near_top_ones", int'(p0o[1]), 8);
    check("near_top_gameOver", int'(go[1]), 0);
    tick(0, 1, 9, 0, 0);
    check("sat_tens", int'(p0t[1]), 9);
    check("sat_ones", int'(p0o[1]), 9);
    check("sat_gameOver", int'(go[1]), 1);
    check("sat_winner", int'(wn[1]), 0);

    // randomized play
    tick(1, 0, 0, 0, 0);
    for (int n = 0; n < 4000; n++) begin
      tick(($urandom_range(0, 299) == 0),
           ($urandom_range(0, 99) < 45),
           int'($urandom_range(0, 15)),
           ($urandom_range(0, 99) < 8),
           ($urandom_range(0, 99) < 25));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
